sgr_encoder: RTL and testbench
==============================

SGR_ENCODER -- requirements
Module: sgr_encoder

Interface
REQ-001 SHALL have parameter EMIT_RESET, default 1; when 1, parameter "0" is emitted first in every sequence.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load, input, 1 bit: request to encode the present graphics inputs.
REQ-005 SHALL have port in_ready, output, 1 bit: encoder idle; load is accepted only when in_ready=1.
REQ-006 SHALL have ports fg and bg, input, 9 bits each: RGB333 colours, R=[8:6], G=[5:3], B=[2:0].
REQ-007 SHALL have ports underline, blink, negative and bright, input, 1 bit each: effect flags.
REQ-008 SHALL have port tx_data, output, 8 bits: ASCII byte of the sequence.
REQ-009 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1 bit: consumer accepts the byte when tx_valid and tx_ready are both 1.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a request completes.

Function
REQ-012 SHALL capture fg, bg and the four flags on the clk edge where load=1 and in_ready=1; later input changes SHALL NOT affect the sequence in flight.
REQ-013 SHALL emit, in order:
- 1B, 5B ("ESC [");
- "0;" when EMIT_RESET=1;
- "1;" if bright, "4;" if underline, "5;" if blink, "7;" if negative;
- "38;2;R;G;B;48;2;R;G;B" (fg, then bg);
- 6D ("m").
REQ-014 SHALL separate parameters with 3B and SHALL NOT place 3B directly before 6D.
REQ-015 SHALL expand each 3-bit component c to 8 bits as {c,c,c[2:1]} (0->0, 1->36, 5->182, 7->255).
REQ-016 SHALL print each component as ASCII decimal, with no leading zeros and "0" for zero, using 1-3 digits.
REQ-017 SHALL use states IDLE, ESC, CSI, RST0, ATTR, COLOR, FINAL:
- IDLE->ESC on an accepted load;
- each state advances only on a byte handshake;
- FINAL->IDLE on the handshake of 6D.
REQ-018 SHALL assert tx_valid with 1B in the cycle after load is accepted.
REQ-019 SHALL hold tx_valid and tx_data stable while tx_valid=1 and tx_ready=0.
REQ-020 SHALL emit back-to-back bytes, one per cycle, while tx_ready stays 1.
REQ-021 SHALL hold in_ready=0 from the accepting edge until return to IDLE; load while busy SHALL be ignored.
REQ-022 SHALL pulse done for exactly one cycle, in the cycle after the 6D handshake; in_ready=1 in that same cycle.
REQ-023 SHALL accept load in the cycle done is high, with no idle gap required.

Reset
REQ-024 SHALL, when rst=0, immediately force: state=IDLE, tx_valid=0, tx_data=8'h00, done=0, in_ready=1, and clear captured registers.
REQ-025 SHALL abandon any sequence in flight on reset without completing it; the next load starts a new sequence at 1B.

Configuration
REQ-026 SHALL implement delta suppression under macro SGR_ENC_DELTA_EN:
- with the macro defined, the last emitted graphics are stored (reset value: all zero);
- a load whose inputs equal the stored value emits no bytes and pulses done in the next cycle;
- without the macro, every accepted load emits a full sequence, and no comparison register exists.

Verification
REQ-027 SHALL cover: EMIT_RESET=1, fg=9'h1C0, bg=0, bright=1, tx_ready=1 -> bytes 1B 5B 30 3B 31 3B 33 38 3B 32 3B 32 35 35 3B 30 3B 30 3B 34 38 3B 32 3B 30 3B 30 3B 30 6D, then done in the next cycle.
REQ-028 SHALL cover: EMIT_RESET=0, flags all 1, fg=bg=9'h049 -> "ESC[1;4;5;7;38;2;36;36;36;48;2;36;36;36m".
REQ-029 SHALL cover: tx_ready toggling randomly -> identical byte stream to REQ-027, with tx_data held stable whenever tx_valid=1 and tx_ready=0.
REQ-030 SHALL cover: rst=0 asserted after the 10th byte -> tx_valid=0 at once; a following load restarts at 1B.
REQ-031 SHALL cover: load pulsed while busy -> ignored, exactly one sequence emitted.
REQ-032 SHALL cover: with SGR_ENC_DELTA_EN, two identical loads -> the second emits no bytes and done pulses one cycle after it.

Source files
------------

// File: rtl/sgr_encoder.sv
// sgr_encoder: serialises RGB333 fg/bg colours and effect flags into an ANSI SGR escape sequence.
// Optional feature: define SGR_ENC_DELTA_EN to suppress requests identical to the last emitted one.
module sgr_encoder #(
    parameter int EMIT_RESET = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic       in_ready,
    input  logic [8:0] fg,
    input  logic [8:0] bg,
    input  logic       underline,
    input  logic       blink,
    input  logic       negative,
    input  logic       bright,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ESC   = 3'd1,
        CSI   = 3'd2,
        RST0  = 3'd3,
        ATTR  = 3'd4,
        COLOR = 3'd5,
        FINAL = 3'd6
    } state_t;

    // pos value 3 marks the ';' that follows a numeric parameter
    localparam logic [1:0] POS_SEP = 2'd3;

    state_t     state_r;
    state_t     nxt_state_s;
    logic [3:0] field_r;
    logic [3:0] nxt_field_s;
    logic [1:0] pos_r;
    logic [1:0] nxt_pos_s;
    logic [8:0] fg_r;
    logic [8:0] bg_r;
    logic [3:0] flags_r;
    logic [7:0] tx_data_r;
    logic       tx_valid_r;
    logic       done_r;
    logic       in_ready_r;
    logic [2:0] attr_from_s;
    logic [2:0] attr_s;
    logic [1:0] ndig_s;
    logic [7:0] nxt_byte_s;
    logic [3:0] flags_in_s;
    logic       accept_s;
    logic       skip_s;

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // Numeric value of the parameter addressed by (state, field).
    function automatic logic [7:0] num_val(input state_t st, input logic [3:0] fld,
                                           input logic [8:0] f, input logic [8:0] b);
        logic [7:0] v;
        v = 8'd0;
        case (st)
            ATTR: begin
                case (fld[1:0])
                    2'd0:    v = 8'd1;
                    2'd1:    v = 8'd4;
                    2'd2:    v = 8'd5;
                    default: v = 8'd7;
                endcase
            end
            COLOR: begin
                case (fld)
                    4'd0:       v = 8'd38;
                    4'd1, 4'd6: v = 8'd2;
                    4'd2:       v = expand3(f[8:6]);
                    4'd3:       v = expand3(f[5:3]);
                    4'd4:       v = expand3(f[2:0]);
                    4'd5:       v = 8'd48;
                    4'd7:       v = expand3(b[8:6]);
                    4'd8:       v = expand3(b[5:3]);
                    4'd9:       v = expand3(b[2:0]);
                    default:    v = 8'd0;
                endcase
            end
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] num_digits(input logic [7:0] v);
        return (v >= 8'd100) ? 2'd3 : ((v >= 8'd10) ? 2'd2 : 2'd1);
    endfunction

    function automatic logic [7:0] digit_char(input logic [7:0] v, input logic [1:0] pos);
        logic [1:0] idx;
        logic [7:0] d;
        idx = num_digits(v) - 2'd1 - pos;
        case (idx)
            2'd2:    d = v / 8'd100;
            2'd1:    d = (v / 8'd10) % 8'd10;
            default: d = v % 8'd10;
        endcase
        return 8'h30 + d;
    endfunction

    function automatic logic [7:0] byte_of(input state_t st, input logic [3:0] fld, input logic [1:0] pos,
                                           input logic [8:0] f, input logic [8:0] b);
        logic [7:0] r;
        case (st)
            ESC:               r = 8'h1B;
            CSI:               r = 8'h5B;
            FINAL:             r = 8'h6D;
            RST0, ATTR, COLOR: r = (pos == POS_SEP) ? 8'h3B : digit_char(num_val(st, fld, f, b), pos);
            default:           r = 8'h00;
        endcase
        return r;
    endfunction

    // Lowest enabled attribute index >= from; bit 2 flags that one was found.
    function automatic logic [2:0] next_attr(input logic [3:0] fl, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            r = (fl[i] && (3'(i) >= from)) ? {1'b1, 2'(i)} : r;
        end
        return r;
    endfunction

    assign flags_in_s = {negative, blink, underline, bright};
    assign accept_s   = load && in_ready_r;

`ifdef SGR_ENC_DELTA_EN
    logic [21:0] last_r;

    assign skip_s = (last_r == {fg, bg, flags_in_s});

    // Remember the graphics of the last sequence actually emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= 22'd0;
        end else if (accept_s && !skip_s) begin
            last_r <= {fg, bg, flags_in_s};
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    // Next-byte pointer: walks the sequence one byte per handshake.
    always_comb begin
        nxt_state_s = state_r;
        nxt_field_s = field_r;
        nxt_pos_s   = pos_r;
        attr_from_s = (state_r == ATTR) ? ({1'b0, field_r[1:0]} + 3'd1) : 3'd0;
        attr_s      = next_attr(flags_r, attr_from_s);
        ndig_s      = num_digits(num_val(state_r, field_r, fg_r, bg_r));
        case (state_r)
            ESC: nxt_state_s = CSI;
            CSI: begin
                nxt_field_s = 4'd0;
                nxt_pos_s   = 2'd0;
                if (EMIT_RESET != 0) begin
                    nxt_state_s = RST0;
                end else if (attr_s[2]) begin
                    nxt_state_s = ATTR;
                    nxt_field_s = {2'b00, attr_s[1:0]};
                end else begin
                    nxt_state_s = COLOR;
                end
            end
            RST0, ATTR, COLOR: begin
                if (pos_r == POS_SEP) begin
                    nxt_pos_s = 2'd0;
                    if (state_r == COLOR) begin
                        nxt_field_s = field_r + 4'd1;
                    end else if (attr_s[2]) begin
                        nxt_state_s = ATTR;
                        nxt_field_s = {2'b00, attr_s[1:0]};
                    end else begin
                        nxt_state_s = COLOR;
                        nxt_field_s = 4'd0;
                    end
                end else if ((pos_r + 2'd1) < ndig_s) begin
                    nxt_pos_s = pos_r + 2'd1;
                end else if ((state_r == COLOR) && (field_r == 4'd9)) begin
                    nxt_state_s = FINAL;
                    nxt_pos_s   = 2'd0;
                end else begin
                    nxt_pos_s = POS_SEP;
                end
            end
            FINAL: begin
                nxt_state_s = IDLE;
                nxt_field_s = 4'd0;
                nxt_pos_s   = 2'd0;
            end
            default: begin
                nxt_state_s = state_r;
            end
        endcase
        nxt_byte_s = byte_of(nxt_state_s, nxt_field_s, nxt_pos_s, fg_r, bg_r);
    end

    // Sequence state, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            field_r    <= 4'd0;
            pos_r      <= 2'd0;
            fg_r       <= 9'd0;
            bg_r       <= 9'd0;
            flags_r    <= 4'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            if (accept_s && skip_s) begin
                done_r <= 1'b1;
            end else if (accept_s) begin
                state_r    <= ESC;
                field_r    <= 4'd0;
                pos_r      <= 2'd0;
                fg_r       <= fg;
                bg_r       <= bg;
                flags_r    <= flags_in_s;
                tx_data_r  <= 8'h1B;
                tx_valid_r <= 1'b1;
                in_ready_r <= 1'b0;
            end else if (tx_valid_r && tx_ready) begin
                state_r <= nxt_state_s;
                field_r <= nxt_field_s;
                pos_r   <= nxt_pos_s;
                if (nxt_state_s == IDLE) begin
                    tx_valid_r <= 1'b0;
                    tx_data_r  <= 8'h00;
                    done_r     <= 1'b1;
                    in_ready_r <= 1'b1;
                end else begin
                    tx_data_r <= nxt_byte_s;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign done     = done_r;
    assign in_ready = in_ready_r;

endmodule

// File: tb/tb_sgr_encoder.sv
// tb_sgr_encoder: randomized self-checking bench for sgr_encoder (EMIT_RESET=1 and =0 instances)
// against a string-building reference model.
module tb_sgr_encoder;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       load_v  [2];
    logic [8:0] fg_v    [2];
    logic [8:0] bg_v    [2];
    logic       ul_v    [2];
    logic       bl_v    [2];
    logic       ng_v    [2];
    logic       br_v    [2];
    logic       rdy_v   [2];
    wire        in_ready_w [2];
    wire  [7:0] tx_data_w  [2];
    wire        tx_valid_w [2];
    wire        done_w     [2];

    int          n_cmp = 0;
    int          n_err = 0;
    bq_t         got0;
    bq_t         got1;
    logic [21:0] last_g [2];
    logic        stall_p [2];
    logic [7:0]  held_d  [2];
    logic        last_m  [2];
    int          n;

    always #5 clk = ~clk;

    sgr_encoder #(.EMIT_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .load(load_v[0]), .in_ready(in_ready_w[0]),
        .fg(fg_v[0]), .bg(bg_v[0]), .underline(ul_v[0]), .blink(bl_v[0]),
        .negative(ng_v[0]), .bright(br_v[0]), .tx_data(tx_data_w[0]),
        .tx_valid(tx_valid_w[0]), .tx_ready(rdy_v[0]), .done(done_w[0])
    );

    sgr_encoder #(.EMIT_RESET(0)) dut1 (
        .clk(clk), .rst(rst), .load(load_v[1]), .in_ready(in_ready_w[1]),
        .fg(fg_v[1]), .bg(bg_v[1]), .underline(ul_v[1]), .blink(bl_v[1]),
        .negative(ng_v[1]), .bright(br_v[1]), .tx_data(tx_data_w[1]),
        .tx_valid(tx_valid_w[1]), .tx_ready(rdy_v[1]), .done(done_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lvl(input logic [2:0] c);
        return 36 * int'(c) + int'(c) / 2;
    endfunction

    function automatic bq_t model(input bit er, input logic [8:0] f, input logic [8:0] b, input logic [3:0] fl);
        bq_t   q;
        string s;
        s = "[";
        if (er)    s = {s, "0;"};
        if (fl[0]) s = {s, "1;"};
        if (fl[1]) s = {s, "4;"};
        if (fl[2]) s = {s, "5;"};
        if (fl[3]) s = {s, "7;"};
        s = {s, $sformatf("38;2;%0d;%0d;%0d;48;2;%0d;%0d;%0d",
                          lvl(f[8:6]), lvl(f[5:3]), lvl(f[2:0]), lvl(b[8:6]), lvl(b[5:3]), lvl(b[2:0]))};
        s = {s, "m"};
        q.push_back(8'h1B);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic drive(input int u, input logic [8:0] f, input logic [8:0] b, input logic [3:0] fl);
        fg_v[u] = f;
        bg_v[u] = b;
        br_v[u] = fl[0];
        ul_v[u] = fl[1];
        bl_v[u] = fl[2];
        ng_v[u] = fl[3];
    endtask

    // collect handshaken bytes; check stall stability and done timing
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (tx_valid_w[0] && rdy_v[0]) got0.push_back(tx_data_w[0]);
            if (tx_valid_w[1] && rdy_v[1]) got1.push_back(tx_data_w[1]);
            for (int u = 0; u < 2; u++) begin
                if (stall_p[u]) begin
                    chk("hold_valid", tx_valid_w[u], 1'b1);
                    chk("hold_data", tx_data_w[u], held_d[u]);
                end
`ifdef SGR_ENC_DELTA_EN
                if (last_m[u]) chk("done_pulse", done_w[u], 1'b1);
`else
                chk("done_pulse", done_w[u], last_m[u]);
`endif
                stall_p[u] <= tx_valid_w[u] && !rdy_v[u];
                held_d[u]  <= tx_data_w[u];
                last_m[u]  <= tx_valid_w[u] && rdy_v[u] && (tx_data_w[u] == 8'h6D);
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                stall_p[u] <= 1'b0;
                last_m[u]  <= 1'b0;
            end
        end
    end

    task automatic run_seq(input int u, input logic [8:0] f, input logic [8:0] b, input logic [3:0] fl,
                           input bit rnd, input bit hold, input bit pre);
        bq_t exp_q;
        bq_t got_q;
        int  cyc;
        bit  seen;
        exp_q = model(u == 0, f, b, fl);
`ifdef SGR_ENC_DELTA_EN
        if (!pre && ({f, b, fl} == last_g[u])) begin
            @(posedge clk); #1;
            drive(u, f, b, fl);
            load_v[u] = 1'b1;
            @(negedge clk);
            chk("dup_idle", in_ready_w[u], 1'b1);
            @(posedge clk); #1;
            load_v[u] = 1'b0;
            @(negedge clk);
            chk("dup_done", done_w[u], 1'b1);
            chk("dup_quiet", tx_valid_w[u], 1'b0);
            chk("dup_ready", in_ready_w[u], 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("dup_done_end", done_w[u], 1'b0);
            return;
        end
        if (!pre) last_g[u] = {f, b, fl};
`endif
        if (u == 0) got0.delete(); else got1.delete();
        if (!pre) begin
            @(posedge clk); #1;
            drive(u, f, b, fl);
            load_v[u] = 1'b1;
            rdy_v[u]  = 1'b1;
            if (u == 0) got0.delete(); else got1.delete();
            @(negedge clk);
            chk("idle_ready", in_ready_w[u], 1'b1);
            @(posedge clk); #1;
            load_v[u] = hold;
            if (!hold) drive(u, 9'($urandom), 9'($urandom), 4'($urandom));
            @(negedge clk);
            chk("first_valid", tx_valid_w[u], 1'b1);
            chk("first_byte", tx_data_w[u], 8'h1B);
            chk("busy", in_ready_w[u], 1'b0);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1;
            rdy_v[u]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            load_v[u] = hold ? 1'b1 : (cyc == 4);
            @(negedge clk);
            seen = done_w[u];
            cyc++;
        end
        chk("done_seen", seen, 1'b1);
        chk("ready_at_done", in_ready_w[u], 1'b1);
        got_q = (u == 0) ? got0 : got1;
        chk("length", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size()) break;
            chk($sformatf("byte%0d_u%0d", i, u), got_q[i], exp_q[i]);
            if (got_q[i] !== exp_q[i]) break;
        end
        @(posedge clk); #1;
        if (hold) begin
            load_v[u] = 1'b0;
            rdy_v[u]  = 1'b0;
        end
        @(negedge clk);
        chk("done_one_cycle", done_w[u], 1'b0);
        if (hold) begin
            chk("chain_valid", tx_valid_w[u], 1'b1);
            chk("chain_byte", tx_data_w[u], 8'h1B);
            chk("chain_busy", in_ready_w[u], 1'b0);
        end else begin
            chk("quiet_after", tx_valid_w[u], 1'b0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            load_v[u] = 1'b0;
            rdy_v[u]  = 1'b1;
            last_g[u] = 22'd0;
            drive(u, 9'd0, 9'd0, 4'd0);
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_valid", tx_valid_w[u], 1'b0);
            chk("reset_data", tx_data_w[u], 8'h00);
            chk("reset_done", done_w[u], 1'b0);
            chk("reset_ready", in_ready_w[u], 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        run_seq(0, 9'h1C0, 9'h000, 4'b0001, 1'b0, 1'b0, 1'b0);
        run_seq(1, 9'h049, 9'h049, 4'b1111, 1'b0, 1'b0, 1'b0);
        run_seq(0, 9'h1C0, 9'h000, 4'b0001, 1'b1, 1'b0, 1'b0);
        run_seq(1, 9'h1FF, 9'h000, 4'b0000, 1'b0, 1'b0, 1'b0);
`ifndef SGR_ENC_DELTA_EN
        run_seq(1, 9'h1A5, 9'h0F3, 4'b0101, 1'b0, 1'b1, 1'b0);
        run_seq(1, 9'h1A5, 9'h0F3, 4'b0101, 1'b1, 1'b0, 1'b1);
`endif

        drive(0, 9'h0AB, 9'h154, 4'b1010);
        @(posedge clk); #1;
        got0.delete();
        rdy_v[0]  = 1'b1;
        load_v[0] = 1'b1;
        @(posedge clk); #1;
        load_v[0] = 1'b0;
        n = 0;
        while (got0.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_10_bytes", got0.size() >= 10, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", tx_valid_w[0], 1'b0);
        chk("midrst_data", tx_data_w[0], 8'h00);
        chk("midrst_ready", in_ready_w[0], 1'b1);
        chk("midrst_done", done_w[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_g[0] = 22'd0;
        last_g[1] = 22'd0;
        repeat (2) begin
            @(negedge clk);
            chk("postrst_quiet", tx_valid_w[0], 1'b0);
        end
        run_seq(0, 9'h0AB, 9'h154, 4'b1010, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int uu;
            uu = $urandom_range(0, 1);
            run_seq(uu, 9'($urandom), 9'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

`ifdef SGR_ENC_DELTA_EN
        run_seq(1, 9'h111, 9'h022, 4'b0010, 1'b0, 1'b0, 1'b0);
        run_seq(1, 9'h111, 9'h022, 4'b0010, 1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
